// File: rtl/tri_bus_demux_rx.sv
// Receive side of the 3-source shared tristate bit bus: per-channel LSB-first
// deserialiser with valid/ack handoff. Optional even parity: define PARITY_CHECK_EN.
module tri_bus_demux_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bus_in,
    input  logic [2:0]       sel,
    input  logic             bus_vld,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [2:0]       dvalid,
    input  logic [2:0]       dack,
    output logic [2:0]       ovf,
    input  logic             ovf_clr,
    output logic [2:0]       perr
);

`ifdef PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    // Shift register keeps every frame bit except the one arriving on completion.
    localparam int SHW = FRAME - 1;
    localparam int CW  = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic [SHW-1:0]   sh_q     [3];
    logic [SHW-1:0]   sh_d     [3];
    logic [CW-1:0]    cnt_q    [3];
    logic [CW-1:0]    cnt_d    [3];
    logic [WIDTH-1:0] dout_q   [3];
    logic [WIDTH-1:0] dout_d   [3];
    logic [2:0]       dvalid_q;
    logic [2:0]       dvalid_d;
    logic [2:0]       ovf_q;
    logic [2:0]       ovf_d;

    logic [2:0]       hit;
    logic [2:0]       done;
    logic [SHW:0]     frame_w  [3];
    logic [WIDTH-1:0] word     [3];

    always_comb begin
        hit = '0;
        if (bus_vld) begin
            case (sel)
                3'b001:  hit[0] = 1'b1;
                3'b010:  hit[1] = 1'b1;
                3'b011:  hit[2] = 1'b1;
                default: hit    = '0;
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            frame_w[i] = {bus_in, sh_q[i]};
            word[i]    = frame_w[i][WIDTH-1:0];
            done[i]    = hit[i] && (cnt_q[i] == LAST);
            sh_d[i]    = hit[i] ? frame_w[i][SHW:1] : sh_q[i];
            if (done[i]) begin
                cnt_d[i] = '0;
            end else if (hit[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    always_comb begin
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        ovf_d    = ovf_q & ~{3{ovf_clr}};
        for (int unsigned i = 0; i < 3; i++) begin
            if (dvalid_q[i] && dack[i]) begin
                dvalid_d[i] = 1'b0;
            end
            // An ack in the completion cycle frees the slot for the new word.
            if (done[i]) begin
                if (!dvalid_q[i] || dack[i]) begin
                    dout_d[i]   = word[i];
                    dvalid_d[i] = 1'b1;
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                sh_q[i]   <= '0;
                cnt_q[i]  <= '0;
                dout_q[i] <= '0;
            end
            dvalid_q <= '0;
            ovf_q    <= '0;
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef PARITY_CHECK_EN
    logic [2:0] perr_q;
    logic [2:0] perr_d;

    always_comb begin
        perr_d = perr_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (dvalid_q[i] && dack[i]) begin
                perr_d[i] = 1'b0;
            end
            if (done[i] && (!dvalid_q[i] || dack[i])) begin
                perr_d[i] = ^frame_w[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= '0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`else
    assign perr = '0;
`endif

    assign dout0  = dout_q[0];
    assign dout1  = dout_q[1];
    assign dout2  = dout_q[2];
    assign dvalid = dvalid_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_tri_bus_demux_rx.sv
// Bench for tri_bus_demux_rx (WIDTH=8): directed vectors, a word-level reference
// model compared every cycle, plus literal expectations for the directed cases.
module tb_tri_bus_demux_rx;

    localparam int W = 8;
`ifdef PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int F = W + int'(PAR);

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         bus_in = 1'b0;
    logic [2:0]   sel = 3'b000;
    logic         bus_vld = 1'b0;
    logic [W-1:0] dout0, dout1, dout2;
    logic [2:0]   dvalid;
    logic [2:0]   dack = 3'b000;
    logic [2:0]   ovf;
    logic         ovf_clr = 1'b0;
    logic [2:0]   perr;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    tri_bus_demux_rx #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .sel(sel), .bus_vld(bus_vld),
        .dout0(dout0), .dout1(dout1), .dout2(dout2), .dvalid(dvalid), .dack(dack),
        .ovf(ovf), .ovf_clr(ovf_clr), .perr(perr)
    );

    always #5 clk = ~clk;

    // Word-level model: bits accumulate arithmetically, words are handed over per the handshake rules.
    int         m_cnt [3];
    int         m_acc [3];
    int         m_par [3];
    logic [7:0] m_dout [3];
    logic [2:0] m_valid, m_ovf, m_perr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0; m_acc[i] = 0; m_par[i] = 0; m_dout[i] = 8'h00;
            end
            m_valid = 3'b000; m_ovf = 3'b000; m_perr = 3'b000;
        end else begin
            int ch;
            logic [2:0] nv, np, no;
            ch = -1;
            if (bus_vld) begin
                if (sel == 3'b001) ch = 0;
                else if (sel == 3'b010) ch = 1;
                else if (sel == 3'b011) ch = 2;
            end
            nv = m_valid; np = m_perr;
            no = ovf_clr ? 3'b000 : m_ovf;
            for (int i = 0; i < 3; i++) begin
                if (m_valid[i] && dack[i]) begin
                    nv[i] = 1'b0; np[i] = 1'b0;
                end
            end
            if (ch >= 0) begin
                if (m_cnt[ch] < W) m_acc[ch] = m_acc[ch] + (int'(bus_in) << m_cnt[ch]);
                m_par[ch] = m_par[ch] ^ int'(bus_in);
                m_cnt[ch] = m_cnt[ch] + 1;
                if (m_cnt[ch] == F) begin
                    if (!m_valid[ch] || dack[ch]) begin
                        m_dout[ch] = m_acc[ch][7:0];
                        nv[ch] = 1'b1;
                        np[ch] = PAR ? m_par[ch][0] : 1'b0;
                    end else begin
                        no[ch] = 1'b1;
                    end
                    m_cnt[ch] = 0; m_acc[ch] = 0; m_par[ch] = 0;
                end
            end
            m_valid = nv; m_perr = np; m_ovf = no;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_dout0", 32'(dout0), 32'(m_dout[0]));
            chk("model_dout1", 32'(dout1), 32'(m_dout[1]));
            chk("model_dout2", 32'(dout2), 32'(m_dout[2]));
            chk("model_dvalid", 32'(dvalid), 32'(m_valid));
            chk("model_ovf", 32'(ovf), 32'(m_ovf));
            chk("model_perr", 32'(perr), 32'(m_perr));
        end
    end

    // Holds the inputs across one rising edge, then returns 1 time unit after it.
    task automatic step(input logic [2:0] s, input logic v, input logic b,
                        input logic [2:0] ack, input logic clr);
        sel = s; bus_vld = v; bus_in = b; dack = ack; ovf_clr = clr;
        @(posedge clk);
        #1;
        sel = 3'b000; bus_vld = 1'b0; bus_in = 1'b0; dack = 3'b000; ovf_clr = 1'b0;
    endtask

    task automatic send_word(input logic [2:0] s, input logic [7:0] w,
                             input logic [2:0] ack_last, input logic clr_last,
                             input logic pflip);
        for (int i = 0; i < F; i++) begin
            logic b;
            b = (i < W) ? w[i] : ((^w) ^ pflip);
            if (i == F - 1) step(s, 1'b1, b, ack_last, clr_last);
            else            step(s, 1'b1, b, 3'b000, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] a, c;
        logic [2:0] idle_sel [3];
        idle_sel[0] = 3'b000; idle_sel[1] = 3'b100; idle_sel[2] = 3'b111;

        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        #10 rst_n = 1'b1;
        chk("reset_dvalid", 32'(dvalid), 32'h0);
        chk("reset_ovf", 32'(ovf), 32'h0);

        // 1: single word on ch0, ack clears valid
        send_word(3'b001, 8'hA5, 3'b000, 1'b0, 1'b0);
        chk("t1_dvalid", 32'(dvalid), 32'h1);
        chk("t1_dout0", 32'(dout0), 32'hA5);
        step(3'b000, 1'b0, 1'b0, 3'b001, 1'b0);
        chk("t1_ack_dvalid", 32'(dvalid), 32'h0);

        // 2: interleaved nibbles on ch1/ch2
        a = 8'h3C; c = 8'hC3;
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < 4; i++) step(3'b010, 1'b1, a[h*4+i], 3'b000, 1'b0);
            for (int i = 0; i < 4; i++) step(3'b011, 1'b1, c[h*4+i], 3'b000, 1'b0);
        end
        if (PAR) begin
            step(3'b010, 1'b1, ^a, 3'b000, 1'b0);
            step(3'b011, 1'b1, ^c, 3'b000, 1'b0);
        end
        chk("t2_dout1", 32'(dout1), 32'h3C);
        chk("t2_dout2", 32'(dout2), 32'hC3);
        chk("t2_dvalid", 32'(dvalid), 32'h6);
        step(3'b000, 1'b0, 1'b0, 3'b110, 1'b0);

        // 3: overflow on ch2, clear, then set-wins-over-clear
        send_word(3'b011, 8'h11, 3'b000, 1'b0, 1'b0);
        send_word(3'b011, 8'h22, 3'b000, 1'b0, 1'b0);
        chk("t3_dout2", 32'(dout2), 32'h11);
        chk("t3_ovf", 32'(ovf), 32'h4);
        step(3'b000, 1'b0, 1'b0, 3'b000, 1'b1);
        chk("t3_ovf_clr", 32'(ovf), 32'h0);
        send_word(3'b011, 8'h33, 3'b000, 1'b1, 1'b0);
        chk("t3_ovf_set_wins", 32'(ovf), 32'h4);
        chk("t3_dout2_kept", 32'(dout2), 32'h11);
        step(3'b000, 1'b0, 1'b0, 3'b100, 1'b1);
        chk("t3_dvalid_after", 32'(dvalid), 32'h0);

        // 4: completion in the same cycle as ack
        send_word(3'b001, 8'h5A, 3'b000, 1'b0, 1'b0);
        send_word(3'b001, 8'h96, 3'b001, 1'b0, 1'b0);
        chk("t4_dout0", 32'(dout0), 32'h96);
        chk("t4_dvalid", 32'(dvalid), 32'h1);
        chk("t4_ovf", 32'(ovf), 32'h0);

        // 5: idle selects ignored; reset mid-word on ch1
        for (int k = 0; k < 20; k++) step(idle_sel[k % 3], 1'b1, 1'b1, 3'b000, 1'b0);
        chk("t5_dvalid_idle", 32'(dvalid), 32'h1);
        chk("t5_dout0_idle", 32'(dout0), 32'h96);
        for (int i = 0; i < 5; i++) step(3'b010, 1'b1, 1'b1, 3'b000, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("t5_rst_dout0", 32'(dout0), 32'h0);
        chk("t5_rst_dout1", 32'(dout1), 32'h0);
        chk("t5_rst_dvalid", 32'(dvalid), 32'h0);
        rst_n = 1'b1;
        send_word(3'b010, 8'hE7, 3'b000, 1'b0, 1'b0);
        chk("t5_dout1", 32'(dout1), 32'hE7);
        chk("t5_dvalid", 32'(dvalid), 32'h2);
        step(3'b000, 1'b0, 1'b0, 3'b010, 1'b0);

`ifdef PARITY_CHECK_EN
        // 6: parity good then bad
        send_word(3'b001, 8'h07, 3'b000, 1'b0, 1'b0);
        chk("t6_perr_good", 32'(perr), 32'h0);
        step(3'b000, 1'b0, 1'b0, 3'b001, 1'b0);
        send_word(3'b001, 8'h07, 3'b000, 1'b0, 1'b1);
        chk("t6_perr_bad", 32'(perr), 32'h1);
        chk("t6_dout0", 32'(dout0), 32'h07);
        step(3'b000, 1'b0, 1'b0, 3'b001, 1'b0);
        chk("t6_perr_clr", 32'(perr), 32'h0);
`else
        send_word(3'b001, 8'h07, 3'b000, 1'b0, 1'b0);
        chk("t6_perr_tied", 32'(perr), 32'h0);
        chk("t6_dout0", 32'(dout0), 32'h07);
`endif

        step(3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
